file_io_arbiter: RTL and testbench

Round-robin arbiter that shares the single simulation file-I/O service channel between the file-I/O detectors of `N_NODES` nodes. Each node raises a level request carrying an instruction word and three argument registers. The arbiter grants one node at a time and latches its payload onto the shared channel. It waits for the simulator's completion pulse, or for a timeout, and returns a one-cycle done pulse to the granted node only. It sits at SoC top level, between the per-node `file_instr_valid/file_instruction/file_reg_a*` outputs and the testbench file-operation handler.

---
 rtl/file_io_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_file_io_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/file_io_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : file_io_arbiter
// Brief    : Round-robin arbiter sharing one simulation file-I/O channel
//            between N_NODES requesters, with optional completion timeout.
// Revision : 1.0 - initial release
// ============================================================================
module file_io_arbiter #(
    parameter int N_NODES = 4,
    parameter int ID_W    = 4,
    parameter int TIMEOUT = 0
) (
    input  logic                    clk,
    input  logic                    res,
    input  logic [N_NODES-1:0]      req_valid,
    input  logic [32*N_NODES-1:0]   req_instr,
    input  logic [32*N_NODES-1:0]   req_a0,
    input  logic [32*N_NODES-1:0]   req_a1,
    input  logic [32*N_NODES-1:0]   req_a2,
    output logic [N_NODES-1:0]      node_done,
    output logic [N_NODES-1:0]      node_err,
    output logic                    out_valid,
    output logic [ID_W-1:0]         out_node_id,
    output logic [31:0]             out_instr,
    output logic [31:0]             out_a0,
    output logic [31:0]             out_a1,
    output logic [31:0]             out_a2,
    input  logic                    sim_done,
    output logic                    busy
);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_ISSUE = 2'd1;
    localparam logic [1:0] c_S_DONE  = 2'd2;
    localparam logic [1:0] c_S_HOLD  = 2'd3;

    localparam logic [31:0]        c_TMO_LAST = 32'(TIMEOUT - 1);
    localparam logic [N_NODES-1:0] c_ONE      = {{(N_NODES-1){1'b0}}, 1'b1};

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [ID_W-1:0]    r_rr_ptr;
    logic [ID_W-1:0]    r_mask_id;
    logic               r_mask_en;
    logic               r_solo;
    logic [31:0]        r_cnt;

    logic [N_NODES-1:0] w_mask_vec;
    logic [N_NODES-1:0] w_elig;
    logic [N_NODES-1:0] w_rot;
    logic [N_NODES-1:0] w_done_vec;
    logic               w_mask_req;
    logic               w_solo;
    logic               w_found;
    logic [ID_W-1:0]    w_sel;
    logic               w_timeout;
    logic               w_complete;
    logic               w_cmpl_err;

    function automatic logic [31:0] pick(input logic [32*N_NODES-1:0] bus,
                                         input logic [ID_W-1:0]        idx);
        return 32'(bus >> (32 * int'(idx)));
    endfunction

    assign w_mask_vec = c_ONE << r_mask_id;
    assign w_elig     = req_valid & ~(r_mask_en ? w_mask_vec : '0);
    assign w_mask_req = |(req_valid & w_mask_vec);
    assign w_solo     = (req_valid == w_mask_vec);
    assign w_found    = |w_elig;
    assign w_timeout  = (TIMEOUT > 0) && (r_cnt == c_TMO_LAST);
    assign w_done_vec = c_ONE << out_node_id;
    assign busy       = (r_state != c_S_IDLE);

    // Rotate so bit 0 is rr_ptr, then the lowest set bit is the winner.
    always_comb begin
        int s;
        s     = 0;
        w_sel = '0;
        w_rot = (w_elig >> r_rr_ptr) | (w_elig << (N_NODES - int'(r_rr_ptr)));
        for (int j = N_NODES - 1; j >= 0; j--) begin
            if (((w_rot >> j) & c_ONE) != '0) begin
                s = int'(r_rr_ptr) + j;
                if (s >= N_NODES) s = s - N_NODES;
                w_sel = ID_W'(s);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_complete  = 1'b0;
        w_cmpl_err  = 1'b0;
        case (r_state)
            c_S_IDLE: begin
                if (w_found) w_state_nxt = c_S_ISSUE;
            end
            c_S_ISSUE: begin
                if (sim_done) begin
                    w_state_nxt = c_S_DONE;
                    w_complete  = 1'b1;
                end else if (w_timeout) begin
                    w_state_nxt = c_S_DONE;
                    w_complete  = 1'b1;
                    w_cmpl_err  = 1'b1;
                end
            end
            c_S_DONE: w_state_nxt = c_S_HOLD;
            default:  w_state_nxt = c_S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) r_state <= c_S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            out_valid   <= 1'b0;
            out_node_id <= '0;
            out_instr   <= '0;
            out_a0      <= '0;
            out_a1      <= '0;
            out_a2      <= '0;
            node_done   <= '0;
            node_err    <= '0;
            r_rr_ptr    <= '0;
            r_mask_id   <= '0;
            r_mask_en   <= 1'b0;
            r_solo      <= 1'b0;
            r_cnt       <= '0;
        end else begin
            node_done <= '0;
            node_err  <= '0;
            case (r_state)
                c_S_IDLE: begin
                    if (w_found) begin
                        out_valid   <= 1'b1;
                        out_node_id <= w_sel;
                        out_instr   <= pick(req_instr, w_sel);
                        out_a0      <= pick(req_a0, w_sel);
                        out_a1      <= pick(req_a1, w_sel);
                        out_a2      <= pick(req_a2, w_sel);
                        r_cnt       <= '0;
                    end
                    // Lift the mask once the served node lets go, or after it
                    // has been the sole requester for two idle cycles.
                    if (r_mask_en) begin
                        if (!w_mask_req) begin
                            r_mask_en <= 1'b0;
                            r_solo    <= 1'b0;
                        end else if (w_solo) begin
                            if (r_solo) begin
                                r_mask_en <= 1'b0;
                                r_solo    <= 1'b0;
                            end else begin
                                r_solo <= 1'b1;
                            end
                        end else begin
                            r_solo <= 1'b0;
                        end
                    end
                end
                c_S_ISSUE: begin
                    if (w_complete) begin
                        out_valid <= 1'b0;
                        node_done <= w_done_vec;
                        node_err  <= w_cmpl_err ? w_done_vec : '0;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                c_S_DONE: begin
                    r_rr_ptr  <= (out_node_id == ID_W'(N_NODES - 1)) ? '0
                                 : out_node_id + ID_W'(1);
                    r_mask_id <= out_node_id;
                    r_mask_en <= 1'b1;
                    r_solo    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_file_io_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_file_io_arbiter
// Brief    : Self-checking bench: directed scenarios plus random traffic,
//            compared every cycle against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_file_io_arbiter;

    localparam int N = 4;
    localparam int T = 8;

    logic          clk = 1'b0;
    logic          res;
    logic          rq[N];
    logic [31:0]   p_instr[N], p_a0[N], p_a1[N], p_a2[N];
    logic [N-1:0]  req_valid;
    logic [32*N-1:0] req_instr, req_a0, req_a1, req_a2;
    logic [N-1:0]  node_done, node_err;
    logic          out_valid, busy, sim_done;
    logic [3:0]    out_node_id;
    logic [31:0]   out_instr, out_a0, out_a1, out_a2;

    assign req_valid = {rq[3], rq[2], rq[1], rq[0]};
    assign req_instr = {p_instr[3], p_instr[2], p_instr[1], p_instr[0]};
    assign req_a0    = {p_a0[3], p_a0[2], p_a0[1], p_a0[0]};
    assign req_a1    = {p_a1[3], p_a1[2], p_a1[1], p_a1[0]};
    assign req_a2    = {p_a2[3], p_a2[2], p_a2[1], p_a2[0]};

    file_io_arbiter #(.N_NODES(N), .ID_W(4), .TIMEOUT(T)) dut (
        .clk(clk), .res(res), .req_valid(req_valid), .req_instr(req_instr),
        .req_a0(req_a0), .req_a1(req_a1), .req_a2(req_a2),
        .node_done(node_done), .node_err(node_err), .out_valid(out_valid),
        .out_node_id(out_node_id), .out_instr(out_instr), .out_a0(out_a0),
        .out_a1(out_a1), .out_a2(out_a2), .sim_done(sim_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    int   m_ptr = 0, m_mask_id = 0, m_solo = 0, m_wait = 0, m_after = 0, m_id = 0;
    bit   m_mask_en = 0, m_active = 0;
    logic        e_valid = 0, e_busy = 0;
    logic [3:0]  e_id = 0, e_done = 0, e_err = 0;
    logic [31:0] e_instr = 0, e_a0 = 0, e_a1 = 0, e_a2 = 0;

    task automatic model_step();
        int  pick, n;
        bit  fin, err;
        if (res) begin
            m_ptr = 0; m_mask_id = 0; m_solo = 0; m_wait = 0; m_after = 0; m_id = 0;
            m_mask_en = 0; m_active = 0;
            e_valid = 0; e_busy = 0; e_id = 0; e_done = 0; e_err = 0;
            e_instr = 0; e_a0 = 0; e_a1 = 0; e_a2 = 0;
            return;
        end
        e_done = 0;
        e_err  = 0;
        if (m_after == 1) begin
            m_after = 2;
        end else if (m_after == 2) begin
            m_after = 0;
            e_busy  = 0;
        end else if (m_active) begin
            fin = 0; err = 0;
            if (sim_done) fin = 1;
            else if (m_wait == T - 1) begin fin = 1; err = 1; end
            else m_wait++;
            if (fin) begin
                m_active  = 0;
                e_valid   = 0;
                e_done    = 4'b0001 << m_id;
                e_err     = err ? e_done : 4'b0000;
                m_after   = 1;
                m_ptr     = (m_id + 1) % N;
                m_mask_id = m_id;
                m_mask_en = 1;
                m_solo    = 0;
            end
        end else begin
            pick = -1;
            for (int d = 0; d < N; d++) begin
                n = (m_ptr + d) % N;
                if (pick < 0 && rq[n] && !(m_mask_en && n == m_mask_id)) pick = n;
            end
            if (m_mask_en) begin
                if (!rq[m_mask_id]) begin
                    m_mask_en = 0; m_solo = 0;
                end else if (req_valid == (4'b0001 << m_mask_id)) begin
                    m_solo++;
                    if (m_solo >= 2) begin m_mask_en = 0; m_solo = 0; end
                end else begin
                    m_solo = 0;
                end
            end
            if (pick >= 0) begin
                m_active = 1; m_wait = 0; m_id = pick;
                e_valid = 1; e_busy = 1; e_id = 4'(pick);
                e_instr = p_instr[pick]; e_a0 = p_a0[pick];
                e_a1 = p_a1[pick]; e_a2 = p_a2[pick];
            end
        end
    endtask

    always @(posedge clk or posedge res) begin
        model_step();
        #1;
        chk("out_valid", out_valid, e_valid);
        chk("out_node_id", out_node_id, e_id);
        chk("out_instr", out_instr, e_instr);
        chk("out_a0", out_a0, e_a0);
        chk("out_a1", out_a1, e_a1);
        chk("out_a2", out_a2, e_a2);
        chk("node_done", node_done, e_done);
        chk("node_err", node_err, e_err);
        chk("busy", busy, e_busy);
    end

    // ---------------- stimulus helpers ----------------
    // mode: 0 off, 1 drop one cycle after done then re-raise, 2 hold forever,
    //       3 one request then off, 4 random
    int mode[N];
    int resp_lat = 0;
    int issue_k = 0;
    int grants[$];
    bit prev_valid = 0;

    function automatic bit bitof(input logic [N-1:0] v, input int i);
        return ((v >> i) & 4'd1) != 4'd0;
    endfunction

    task automatic raise(input int i);
        rq[i] = 1'b1;
        p_instr[i] = $urandom; p_a0[i] = $urandom;
        p_a1[i] = $urandom;    p_a2[i] = $urandom;
    endtask

    task automatic drive_cycle();
        if (out_valid && !prev_valid) grants.push_back(int'(out_node_id));
        prev_valid = out_valid;
        for (int i = 0; i < N; i++) begin
            case (mode[i])
                0: rq[i] = 1'b0;
                1: if (bitof(node_done, i)) rq[i] = 1'b0; else if (!rq[i]) raise(i);
                2: if (!rq[i]) raise(i);
                3: if (bitof(node_done, i)) begin rq[i] = 1'b0; mode[i] = 0; end
                   else if (!rq[i]) raise(i);
                default: begin
                    if (bitof(node_done, i)) begin
                        if ($urandom_range(0, 3) != 0) rq[i] = 1'b0;
                    end else if (!rq[i]) begin
                        if ($urandom_range(0, 3) == 0) raise(i);
                    end else if ($urandom_range(0, 63) == 0) begin
                        rq[i] = 1'b0;
                    end
                end
            endcase
        end
        if (out_valid) issue_k++; else issue_k = 0;
        if (resp_lat == -2) sim_done = ($urandom_range(0, 4) == 0);
        else if (resp_lat > 0) sim_done = out_valid && (issue_k == resp_lat);
        else sim_done = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) begin @(negedge clk); drive_cycle(); end
    endtask

    task automatic run_until_grants(input int want, input int budget);
        for (int c = 0; c < budget && grants.size() < want; c++) begin
            @(negedge clk); drive_cycle();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        res = 1'b1; sim_done = 1'b0;
        for (int i = 0; i < N; i++) begin rq[i] = 1'b0; mode[i] = 0; end
        repeat (2) @(negedge clk);
        res = 1'b0;
        grants.delete(); prev_valid = 0; issue_k = 0;
    endtask

    int rr_exp[6] = '{0, 1, 3, 0, 1, 3};
    int wm_exp[3] = '{2, 3, 0};
    int cnt;

    initial begin
        res = 1'b1; sim_done = 1'b0;
        for (int i = 0; i < N; i++) begin
            rq[i] = 1'b0; mode[i] = 0;
            p_instr[i] = 0; p_a0[i] = 0; p_a1[i] = 0; p_a2[i] = 0;
        end
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_node_done", node_done, 0);
        res = 1'b0;
        @(negedge clk);

        // single request from node 2
        p_instr[2] = 32'h0000_0013; p_a0[2] = 32'h11; p_a1[2] = 32'h22; p_a2[2] = 32'h33;
        rq[2] = 1'b1;
        @(negedge clk);
        chk("single_valid", out_valid, 1);
        chk("single_id", out_node_id, 2);
        chk("single_instr", out_instr, 32'h13);
        chk("single_a0", out_a0, 32'h11);
        chk("single_a1", out_a1, 32'h22);
        chk("single_a2", out_a2, 32'h33);
        repeat (4) @(negedge clk);
        sim_done = 1'b1;
        @(negedge clk);
        sim_done = 1'b0;
        chk("single_done", node_done, 4'b0100);
        chk("single_err", node_err, 4'b0000);
        chk("single_valid_low", out_valid, 0);
        rq[2] = 1'b0;
        @(negedge clk);
        chk("single_done_1cyc", node_done, 4'b0000);
        repeat (3) @(negedge clk);

        // round robin among 0, 1, 3
        do_reset();
        mode[0] = 1; mode[1] = 1; mode[3] = 1; resp_lat = 2;
        run_until_grants(6, 300);
        chk("rr_grant_count", grants.size(), 6);
        for (int k = 0; k < 6 && k < grants.size(); k++) chk("rr_order", grants[k], rr_exp[k]);
        for (int i = 0; i < N; i++) mode[i] = 0;
        run(30);

        // wrap from rr_ptr=3 with node 3 holding its request
        do_reset();
        resp_lat = 2; mode[2] = 3;
        run(20);
        mode[3] = 2; mode[0] = 3;
        run_until_grants(3, 300);
        chk("wrap_grant_count", grants.size(), 3);
        for (int k = 0; k < 3 && k < grants.size(); k++) chk("wrap_order", grants[k], wm_exp[k]);
        for (int i = 0; i < N; i++) mode[i] = 0;
        run(30);
        sim_done = 1'b0;

        // timeout on node 1
        raise(1);
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (node_done != 0) break;
            if (out_valid) cnt++;
        end
        chk("tmo_valid_cycles", cnt, T);
        chk("tmo_done", node_done, 4'b0010);
        chk("tmo_err", node_err, 4'b0010);
        rq[1] = 1'b0;
        @(negedge clk);
        chk("tmo_busy_hold", busy, 1);
        @(negedge clk);
        chk("tmo_busy_idle", busy, 0);

        // sim_done coinciding with timeout expiry
        raise(0);
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            sim_done = 1'b0;
            if (node_done != 0) break;
            if (out_valid) begin
                cnt++;
                if (cnt == T) sim_done = 1'b1;
            end
        end
        sim_done = 1'b0;
        chk("coinc_valid_cycles", cnt, T);
        chk("coinc_done", node_done, 4'b0001);
        chk("coinc_err", node_err, 4'b0000);
        rq[0] = 1'b0;
        repeat (3) @(negedge clk);

        // sim_done while idle
        sim_done = 1'b1;
        @(negedge clk);
        sim_done = 1'b0;
        chk("idle_simdone_done", node_done, 0);
        chk("idle_simdone_busy", busy, 0);
        @(negedge clk);
        chk("idle_simdone_done2", node_done, 0);

        // reset during ISSUE
        raise(2);
        repeat (2) @(negedge clk);
        chk("pre_rst_valid", out_valid, 1);
        res = 1'b1;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_id", out_node_id, 0);
        chk("async_rst_instr", out_instr, 0);
        chk("async_rst_a0", out_a0, 0);
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", node_done, 0);
        rq[2] = 1'b0;
        repeat (2) begin @(negedge clk); chk("rst_no_done", node_done, 0); end
        res = 1'b0;
        for (int i = 0; i < N; i++) begin raise(i); mode[i] = 3; end
        @(negedge clk);
        chk("post_rst_valid", out_valid, 1);
        chk("post_rst_id", out_node_id, 0);
        grants.delete(); prev_valid = 1; issue_k = 1; resp_lat = 3;
        run(80);

        // random traffic
        for (int i = 0; i < N; i++) mode[i] = 4;
        resp_lat = -2;
        run(2000);
        for (int i = 0; i < N; i++) mode[i] = 0;
        run(40);
        sim_done = 1'b0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
